// File: rtl/job_writer.sv
// job_writer: writes a 4-word row descriptor into a worker's register window
// for each dispatcher request, then pulses jw_done. It owns the frame row
// counter and the imaginary-axis accumulator for the Julia-set generator.
//
// Write bus handshake: wr_write is the valid and !wr_waitrequest is the ready.
// A word transfers on a clock edge where both are true. While valid is high
// and ready is low, wr_addr and wr_data hold their values. Valid never drops
// without a transfer, except on a frame restart or a reset.
module job_writer #(
  parameter int          NUM_ROWS  = 480,
  parameter int          ROW_W     = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        wr_clk,
  input  logic        wr_n_rst,
  input  logic        wr_start_calc,
  input  logic [31:0] cfg_y0,
  input  logic [31:0] cfg_step,
  input  logic [31:0] cfg_c_re,
  input  logic [31:0] cfg_c_im,
  input  logic        jw_begin,
  input  logic [3:0]  worker_to_assign,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_write,
  input  logic        wr_waitrequest,
  output logic        jw_done,
  output logic        jw_busy,
  output logic        frame_issued,
  output logic        jw_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [31:0]      y_cur;
  logic [31:0]      step;
  logic [31:0]      c_re;
  logic [31:0]      c_im;
  logic [3:0]       worker;
  logic [1:0]       word_idx;
  logic             armed;

  // Each worker owns a 16-byte window; the word index selects a 32-bit slot.
  function automatic logic [31:0] word_addr(input logic [3:0] w,
                                            input logic [1:0] idx);
    return BASE_ADDR + {24'b0, w, idx, 2'b00};
  endfunction

  // Descriptor layout: row number, imaginary coordinate, then the constant.
  function automatic logic [31:0] word_data(input logic [1:0]       idx,
                                            input logic [ROW_W-1:0] r,
                                            input logic [31:0]      y,
                                            input logic [31:0]      cr,
                                            input logic [31:0]      ci);
    case (idx)
      2'd0:    return {{(32 - ROW_W){1'b0}}, r};
      2'd1:    return y;
      2'd2:    return cr;
      default: return ci;
    endcase
  endfunction

  assign dbg_state = state;

  // Descriptor FSM. The frame restart has priority over all other activity.
  // Row and y_cur advance on the edge that makes jw_done high, so
  // frame_issued rises together with the last jw_done of the frame.
  always_ff @(posedge wr_clk or negedge wr_n_rst) begin
    if (!wr_n_rst) begin
      state        <= IDLE;
      row          <= '0;
      y_cur        <= '0;
      step         <= '0;
      c_re         <= '0;
      c_im         <= '0;
      worker       <= '0;
      word_idx     <= '0;
      armed        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_write     <= 1'b0;
      jw_done      <= 1'b0;
      jw_busy      <= 1'b0;
      frame_issued <= 1'b0;
      jw_err       <= 1'b0;
    end else if (wr_start_calc) begin
      // Any in-flight descriptor is abandoned without a jw_done.
      state        <= IDLE;
      row          <= '0;
      y_cur        <= cfg_y0;
      step         <= cfg_step;
      c_re         <= cfg_c_re;
      c_im         <= cfg_c_im;
      word_idx     <= '0;
      armed        <= 1'b1;
      wr_write     <= 1'b0;
      jw_done      <= 1'b0;
      jw_busy      <= 1'b0;
      frame_issued <= 1'b0;
      jw_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (jw_begin) begin
            if (armed && !frame_issued) begin
              worker   <= worker_to_assign;
              word_idx <= 2'd0;
              jw_busy  <= 1'b1;
              wr_write <= 1'b1;
              wr_addr  <= word_addr(worker_to_assign, 2'd0);
              wr_data  <= word_data(2'd0, row, y_cur, c_re, c_im);
              state    <= WRITE;
            end else begin
              jw_err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (jw_begin) jw_err <= 1'b1;
          if (!wr_waitrequest) begin
            if (word_idx == 2'd3) begin
              wr_write <= 1'b0;
              jw_done  <= 1'b1;
              row      <= row + 1'b1;
              y_cur    <= y_cur - step;
              if (row == LAST_ROW) frame_issued <= 1'b1;
              state    <= DONE;
            end else begin
              word_idx <= word_idx + 2'd1;
              wr_addr  <= word_addr(worker, word_idx + 2'd1);
              wr_data  <= word_data(word_idx + 2'd1, row, y_cur, c_re, c_im);
            end
          end
        end
        DONE: begin
          if (jw_begin) jw_err <= 1'b1;
          jw_done <= 1'b0;
          jw_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_job_writer.sv
// Bench for job_writer: directed scenarios with randomized data, worker
// indices and stalls, checked against a row/coordinate model of the frame.
module tb_job_writer;

  localparam int          NUM_ROWS  = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  // Clock and reset
  logic wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  logic        wr_n_rst = 1'b0;
  logic        wr_start_calc = 1'b0;
  logic [31:0] cfg_y0 = '0, cfg_step = '0, cfg_c_re = '0, cfg_c_im = '0;
  logic        jw_begin = 1'b0;
  logic [3:0]  worker_to_assign = '0;
  logic        wr_waitrequest = 1'b0;
  logic [31:0] wr_addr, wr_data;
  logic        wr_write, jw_done, jw_busy, frame_issued, jw_err;
  logic [1:0]  dbg_state;

  job_writer #(.NUM_ROWS(NUM_ROWS), .ROW_W(10), .BASE_ADDR(BASE_ADDR)) dut (
    .wr_clk(wr_clk), .wr_n_rst(wr_n_rst), .wr_start_calc(wr_start_calc),
    .cfg_y0(cfg_y0), .cfg_step(cfg_step), .cfg_c_re(cfg_c_re), .cfg_c_im(cfg_c_im),
    .jw_begin(jw_begin), .worker_to_assign(worker_to_assign),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_write(wr_write),
    .wr_waitrequest(wr_waitrequest), .jw_done(jw_done), .jw_busy(jw_busy),
    .frame_issued(frame_issued), .jw_err(jw_err), .dbg_state(dbg_state)
  );

  // Scoreboard and frame model
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_y0, m_step, m_cre, m_cim;
  int          m_row = 0;
  bit          m_err = 1'b0;
  bit          m_frame = 1'b0;

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic randomize_cfg();
    cfg_y0   = $urandom;
    cfg_step = $urandom;
    cfg_c_re = $urandom;
    cfg_c_im = $urandom;
  endtask

  // Frame restart; the config inputs are scrambled afterwards since later
  // changes must not reach the descriptors.
  task automatic start_frame(input logic [31:0] y0, input logic [31:0] st,
                             input logic [31:0] cr, input logic [31:0] ci);
    cfg_y0 = y0; cfg_step = st; cfg_c_re = cr; cfg_c_im = ci;
    wr_start_calc = 1'b1;
    tick();
    wr_start_calc = 1'b0;
    m_y0 = y0; m_step = st; m_cre = cr; m_cim = ci;
    m_row = 0; m_err = 1'b0; m_frame = 1'b0;
    exp_q.delete();
    randomize_cfg();
    check1("start_err_clear", jw_err, 1'b0);
    check1("start_frame_clear", frame_issued, 1'b0);
  endtask

  // Row r of the frame sits at y0 - r*step, modulo 2**32.
  task automatic model_push(input logic [3:0] w);
    logic [31:0] y;
    logic [31:0] d;
    y = m_y0 - m_step * 32'(m_row);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: d = 32'(m_row);
        1: d = y;
        2: d = m_cre;
        default: d = m_cim;
      endcase
      exp_q.push_back({BASE_ADDR + 32'(w) * 32'd16 + 32'(i) * 32'd4, d});
    end
  endtask

  // One job. stall_word/stall_n force a stall, rand_stall adds random ones,
  // err_word pulses jw_begin during that word, abort_word restarts the frame.
  task automatic run_job(input logic [3:0] w, input int stall_word, input int stall_n,
                         input bit rand_stall, input int err_word, input int abort_word);
    logic [63:0] exp;
    int          s;
    bit          aborted;
    bit          pend_err;
    model_push(w);
    jw_begin = 1'b1;
    worker_to_assign = w;
    tick();
    jw_begin = 1'b0;
    worker_to_assign = 4'($urandom);
    check1("busy_rise", jw_busy, 1'b1);
    aborted = 1'b0;
    for (int idx = 0; idx < 4 && !aborted; idx++) begin
      exp = exp_q.pop_front();
      check1("word_write", wr_write, 1'b1);
      check("word_addr", wr_addr, exp[63:32]);
      check("word_data", wr_data, exp[31:0]);
      check1("done_early", jw_done, 1'b0);
      if (idx == abort_word) begin
        randomize_cfg();
        wr_start_calc = 1'b1;
        tick();
        wr_start_calc = 1'b0;
        m_y0 = cfg_y0; m_step = cfg_step; m_cre = cfg_c_re; m_cim = cfg_c_im;
        m_row = 0; m_err = 1'b0; m_frame = 1'b0;
        exp_q.delete();
        randomize_cfg();
        check1("abort_write_low", wr_write, 1'b0);
        check1("abort_busy_low", jw_busy, 1'b0);
        check1("abort_no_done", jw_done, 1'b0);
        tick();
        check1("abort_no_done2", jw_done, 1'b0);
        check1("abort_write_low2", wr_write, 1'b0);
        aborted = 1'b1;
      end else begin
        s = (idx == stall_word) ? stall_n : (rand_stall ? int'($urandom_range(0, 2)) : 0);
        pend_err = (idx == err_word);
        if (pend_err) m_err = 1'b1;
        for (int k = 0; k < s; k++) begin
          wr_waitrequest = 1'b1;
          jw_begin = pend_err;
          pend_err = 1'b0;
          tick();
          jw_begin = 1'b0;
          check1("stall_write", wr_write, 1'b1);
          check("stall_addr", wr_addr, exp[63:32]);
          check("stall_data", wr_data, exp[31:0]);
          check1("stall_no_done", jw_done, 1'b0);
        end
        wr_waitrequest = 1'b0;
        jw_begin = pend_err;
        tick();
        jw_begin = 1'b0;
        wr_waitrequest = 1'($urandom);
      end
    end
    wr_waitrequest = 1'b0;
    if (!aborted) begin
      m_row++;
      if (m_row == NUM_ROWS) m_frame = 1'b1;
      check1("done_pulse", jw_done, 1'b1);
      check1("done_write_low", wr_write, 1'b0);
      check1("done_busy", jw_busy, 1'b1);
      check1("done_frame_issued", frame_issued, m_frame);
      tick();
      check1("done_fall", jw_done, 1'b0);
      check1("busy_fall", jw_busy, 1'b0);
      check1("job_err", jw_err, m_err);
      check1("idle_frame_issued", frame_issued, m_frame);
    end
  endtask

  // A request that must be refused: no bus activity, sticky error set.
  task automatic reject_begin(input string tag);
    jw_begin = 1'b1;
    worker_to_assign = 4'($urandom);
    tick();
    jw_begin = 1'b0;
    m_err = 1'b1;
    check1({tag, "_write"}, wr_write, 1'b0);
    check1({tag, "_busy"}, jw_busy, 1'b0);
    check1({tag, "_err"}, jw_err, 1'b1);
    tick();
    check1({tag, "_write2"}, wr_write, 1'b0);
    check1({tag, "_done"}, jw_done, 1'b0);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    check("rst_addr", wr_addr, 32'h0);
    check("rst_data", wr_data, 32'h0);
    check1("rst_write", wr_write, 1'b0);
    check1("rst_done", jw_done, 1'b0);
    check1("rst_busy", jw_busy, 1'b0);
    check1("rst_frame", frame_issued, 1'b0);
    check1("rst_err", jw_err, 1'b0);
    wr_n_rst = 1'b1;
    tick();

    // Not armed until the first frame start
    reject_begin("unarmed");

    // Directed frame: worker 3, then worker 15, then a 3-cycle stall on word 2
    start_frame(32'h1000_0000, 32'h0044_4444, $urandom, $urandom);
    run_job(4'd3, -1, 0, 1'b0, -1, -1);
    run_job(4'd15, -1, 0, 1'b0, -1, -1);
    run_job(4'd3, 2, 3, 1'b0, -1, -1);
    // Last row with a jw_begin during WRITE, then one after frame_issued
    run_job(4'($urandom), -1, 0, 1'b1, 1, -1);
    reject_begin("after_frame");

    // Restart during word 1, then a full random frame from row 0
    start_frame($urandom, $urandom, $urandom, $urandom);
    run_job(4'($urandom), -1, 0, 1'b0, -1, 1);
    for (int j = 0; j < NUM_ROWS; j++) begin
      run_job(4'($urandom), -1, 0, 1'b1, -1, -1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
    check1("rand_frame_issued", frame_issued, 1'b1);
    reject_begin("rand_after_frame");

    // Asynchronous reset in the middle of a descriptor
    start_frame($urandom, $urandom, $urandom, $urandom);
    jw_begin = 1'b1;
    worker_to_assign = 4'd9;
    tick();
    jw_begin = 1'b0;
    tick();
    check1("pre_reset_write", wr_write, 1'b1);
    #2;
    wr_n_rst = 1'b0;
    #1;
    check1("async_write", wr_write, 1'b0);
    check1("async_busy", jw_busy, 1'b0);
    check1("async_done", jw_done, 1'b0);
    check("async_addr", wr_addr, 32'h0);
    check("async_data", wr_data, 32'h0);
    tick();
    wr_n_rst = 1'b1;
    m_row = 0; m_err = 1'b0; m_frame = 1'b0;
    tick();
    reject_begin("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
